// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, framing constants, scheduler state and
// the registered output bundle of the transmit scheduler.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_e;

    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
    localparam logic [3:0] EOP_SE0_BITS = 4'd2;

    // Counter terminal values; EOP ends on the J bit that follows the SE0s.
    localparam logic [3:0] BYTE_LAST  = 4'd7;
    localparam logic [3:0] FIELD_LAST = 4'd10;
    localparam logic [3:0] EOP_LAST   = EOP_SE0_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_FIELD,
        ST_CRC,
        ST_EOP
    } sched_state_e;

    typedef struct packed {
        logic tx_active;
        logic tx_bit;
        logic eop_se0;
        logic crc_inb;
        logic crc_recving;
        logic tx_sel_crc;
        logic hs_done;
        logic tok_done;
    } tx_out_t;

    // PID byte as it goes on the wire: check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// Request, CRC hand-off and serial-output signals of the USB transmit scheduler.
// master: the scheduler side; slave: requesters, CRC block and bit-stuffer side.
interface usb_tx_sched_if;

    logic        hs_req;
    logic [3:0]  hs_pid;
    logic        tok_req;
    logic [3:0]  tok_pid;
    logic [10:0] tok_field;
    logic        stuff_pause;
    logic        crc_sending;

    logic        crc_inb;
    logic        crc_recving;
    logic        tx_bit;
    logic        tx_sel_crc;
    logic        tx_active;
    logic        eop_se0;
    logic        hs_done;
    logic        tok_done;

    modport master (
        input  hs_req, hs_pid, tok_req, tok_pid, tok_field, stuff_pause, crc_sending,
        output crc_inb, crc_recving, tx_bit, tx_sel_crc, tx_active, eop_se0,
               hs_done, tok_done
    );

    modport slave (
        output hs_req, hs_pid, tok_req, tok_pid, tok_field, stuff_pause, crc_sending,
        input  crc_inb, crc_recving, tx_bit, tx_sel_crc, tx_active, eop_se0,
               hs_done, tok_done
    );

endinterface

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and enable; also exposes its
// next value so callers can register outputs that track the count.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] d_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;
    assign d_o = cnt_d;

endmodule

// File: rtl/tx_sched_arb.sv
// Handshake/token arbiter with the latched grant of the packet in flight.
// USB_TX_SCHED_RR_EN selects two-way round-robin instead of handshake priority.
module tx_sched_arb (
    input  logic clk,
    input  logic rst_L,
    input  logic hs_req_i,
    input  logic tok_req_i,
    input  logic grant_en_i,
    output logic req_any_o,
    output logic win_hs_o,
    output logic grant_hs_o
);

    logic grant_hs_q;
    logic prio_hs;

`ifdef USB_TX_SCHED_RR_EN
    // The last grant doubles as the pointer; its reset value (token) puts
    // handshake first after reset.
    assign prio_hs = ~grant_hs_q;
`else
    // Handshake turnaround is time-critical, so it always wins a tie.
    assign prio_hs = 1'b1;
`endif

    assign req_any_o = hs_req_i | tok_req_i;
    assign win_hs_o  = hs_req_i & (~tok_req_i | prio_hs);

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            grant_hs_q <= 1'b0;
        end else if (grant_en_i && req_any_o) begin
            grant_hs_q <= win_hs_o;
        end
    end

    assign grant_hs_o = grant_hs_q;

endmodule

// File: rtl/usb_tx_sched.sv
// USB host transmit scheduler: arbitrates handshake vs token requests and frames
// SYNC, PID, token field, CRC5 hand-off and EOP bit-serially, honouring stuff_pause.
module usb_tx_sched
    import usb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_L,
    usb_tx_sched_if.master     bus
);

    sched_state_e state_q;
    sched_state_e state_d;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic         cnt_clr;
    logic         cnt_en;
    logic         req_any;
    logic         win_hs;
    logic         grant_hs;
    logic         in_idle;
    logic [7:0]   pid_byte_q;
    logic [10:0]  field_q;
    tx_out_t      out_q;
    tx_out_t      out_d;

    assign in_idle = (state_q == ST_IDLE);

    tx_sched_arb u_arb (
        .clk        (clk),
        .rst_L      (rst_L),
        .hs_req_i   (bus.hs_req),
        .tok_req_i  (bus.tok_req),
        .grant_en_i (in_idle),
        .req_any_o  (req_any),
        .win_hs_o   (win_hs),
        .grant_hs_o (grant_hs)
    );

    counter #(
        .WIDTH (4)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_L (rst_L),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (cnt_q),
        .d_o   (cnt_d)
    );

    // A paused cycle leaves state and count untouched, which also freezes the
    // outputs because they are decoded from the next state and count.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (req_any) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!bus.stuff_pause) begin
                    if (cnt_q == BYTE_LAST) begin
                        cnt_clr = 1'b1;
                        state_d = ST_PID;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_PID: begin
                if (!bus.stuff_pause) begin
                    if (cnt_q == BYTE_LAST) begin
                        cnt_clr = 1'b1;
                        state_d = grant_hs ? ST_EOP : ST_FIELD;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_FIELD: begin
                if (!bus.stuff_pause) begin
                    if (cnt_q == FIELD_LAST) begin
                        cnt_clr = 1'b1;
                        state_d = ST_CRC;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                // The CRC block absorbs pauses itself; just wait for it to finish.
                cnt_clr = 1'b1;
                if (!bus.crc_sending) begin
                    state_d = ST_EOP;
                end
            end
            ST_EOP: begin
                if (!bus.stuff_pause) begin
                    if (cnt_q == EOP_LAST) begin
                        cnt_clr = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d = '0;
        unique case (state_d)
            ST_SYNC: begin
                out_d.tx_active = 1'b1;
                out_d.tx_bit    = SYNC_PATTERN[cnt_d[2:0]];
            end
            ST_PID: begin
                out_d.tx_active = 1'b1;
                out_d.tx_bit    = pid_byte_q[cnt_d[2:0]];
            end
            ST_FIELD: begin
                // CRC block passes inb straight through to outb while receiving.
                out_d.tx_active   = 1'b1;
                out_d.crc_recving = 1'b1;
                out_d.tx_sel_crc  = 1'b1;
                out_d.crc_inb     = field_q[cnt_d];
            end
            ST_CRC: begin
                out_d.tx_active  = 1'b1;
                out_d.tx_sel_crc = 1'b1;
            end
            ST_EOP: begin
                out_d.tx_active = 1'b1;
                out_d.eop_se0   = (cnt_d < EOP_SE0_BITS);
                out_d.tx_bit    = (cnt_d >= EOP_SE0_BITS);
                if (cnt_d == EOP_LAST) begin
                    out_d.hs_done  = grant_hs;
                    out_d.tok_done = ~grant_hs;
                end
            end
            default: begin
                out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            pid_byte_q <= '0;
            field_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (in_idle && req_any) begin
                pid_byte_q <= pid_byte(win_hs ? bus.hs_pid : bus.tok_pid);
                field_q    <= bus.tok_field;
            end
        end
    end

    assign bus.tx_active   = out_q.tx_active;
    assign bus.tx_bit      = out_q.tx_bit;
    assign bus.eop_se0     = out_q.eop_se0;
    assign bus.crc_inb     = out_q.crc_inb;
    assign bus.crc_recving = out_q.crc_recving;
    assign bus.tx_sel_crc  = out_q.tx_sel_crc;
    assign bus.hs_done     = out_q.hs_done;
    assign bus.tok_done    = out_q.tok_done;

endmodule
